// File: rtl/bsg_dmc_pearl_tag_sequencer.sv
// Serializes reset/data packets onto the single-wire bsg_tag bus for the DMC pearl tag clients,
// with an optional post-reset sweep that resets every client node in order.
module bsg_dmc_pearl_tag_sequencer #(
  parameter int els_p               = 32,
  parameter int max_payload_width_p = 16,
  parameter int clk_div_p           = 1,
  parameter int gap_p               = 2,
  localparam int lg_els_lp          = $clog2(els_p),
  localparam int lg_width_lp        = $clog2(max_payload_width_p + 1)
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           sweep_en_i,
  input  logic                           v_i,
  input  logic [lg_els_lp-1:0]           node_id_i,
  input  logic                           data_not_reset_i,
  input  logic [lg_width_lp-1:0]         len_i,
  input  logic [max_payload_width_p-1:0] payload_i,
  output logic                           ready_o,
  output logic                           tag_data_o,
  output logic                           busy_o,
  output logic                           sweep_done_o,
  output logic                           err_o
);

  localparam int frame_max_lp = 2 + lg_els_lp + lg_width_lp + max_payload_width_p;
  localparam int bit_w_lp     = $clog2(frame_max_lp);
  localparam int div_w_lp     = (clk_div_p > 1) ? $clog2(clk_div_p) : 1;
  localparam int gap_cyc_lp   = gap_p * clk_div_p;
  localparam int gap_w_lp     = $clog2(gap_cyc_lp + 1);

  localparam logic [bit_w_lp-1:0]    hdr_last_lp   = bit_w_lp'(1 + lg_els_lp + lg_width_lp);
  localparam logic [bit_w_lp-1:0]    sweep_last_lp = bit_w_lp'(frame_max_lp - 1);
  localparam logic [div_w_lp-1:0]    div_last_lp   = div_w_lp'(clk_div_p - 1);
  localparam logic [gap_w_lp-1:0]    gap_last_lp   = gap_w_lp'(gap_cyc_lp - 1);
  localparam logic [lg_els_lp-1:0]   node_last_lp  = lg_els_lp'(els_p - 1);
  localparam logic [lg_els_lp:0]     els_lp        = (lg_els_lp + 1)'(els_p);
  localparam logic [lg_width_lp-1:0] max_len_lp    = lg_width_lp'(max_payload_width_p);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_SWEEP_SHIFT,
    ST_SWEEP_GAP
  } state_e;

  state_e                    state_r, state_n;
  logic [frame_max_lp-1:0]   frame_r, frame_n;
  logic [bit_w_lp-1:0]       last_bit_r, last_bit_n;
  logic [bit_w_lp-1:0]       bit_cnt_r, bit_cnt_n;
  logic [div_w_lp-1:0]       div_cnt_r, div_cnt_n;
  logic [gap_w_lp-1:0]       gap_cnt_r, gap_cnt_n;
  logic [lg_els_lp-1:0]      node_r, node_n;
  logic                      tag_n, ready_n, busy_n, done_n, err_n;
  logic                      illegal;

  // Frame goes out LSB first: start bit, node id, data_not_reset, len, payload.
  function automatic logic [frame_max_lp-1:0] pack_frame(
    input logic [lg_els_lp-1:0]           node,
    input logic                           dnr,
    input logic [lg_width_lp-1:0]         len,
    input logic [max_payload_width_p-1:0] payload
  );
    return {payload, len, dnr, node, 1'b1};
  endfunction

  assign illegal = ({1'b0, node_id_i} >= els_lp) | (len_i > max_len_lp);

  always_comb begin
    state_n    = state_r;
    frame_n    = frame_r;
    last_bit_n = last_bit_r;
    bit_cnt_n  = bit_cnt_r;
    div_cnt_n  = div_cnt_r;
    gap_cnt_n  = gap_cnt_r;
    node_n     = node_r;
    tag_n      = 1'b0;
    ready_n    = ready_o;
    busy_n     = busy_o;
    done_n     = sweep_done_o;
    err_n      = 1'b0;

    case (state_r)
      ST_INIT: begin
        if (sweep_en_i) begin
          state_n    = ST_SWEEP_SHIFT;
          node_n     = '0;
          frame_n    = pack_frame('0, 1'b0, max_len_lp, '1);
          last_bit_n = sweep_last_lp;
          bit_cnt_n  = '0;
          div_cnt_n  = '0;
          tag_n      = 1'b1;
          ready_n    = 1'b0;
          busy_n     = 1'b1;
          done_n     = 1'b0;
        end else begin
          state_n = ST_IDLE;
          ready_n = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end

      ST_IDLE: begin
        if (v_i && ready_o) begin
          if (illegal) begin
            err_n = 1'b1;
          end else begin
            state_n    = ST_SHIFT;
            frame_n    = pack_frame(node_id_i, data_not_reset_i, len_i, payload_i);
            last_bit_n = hdr_last_lp + bit_w_lp'(len_i);
            bit_cnt_n  = '0;
            div_cnt_n  = '0;
            tag_n      = 1'b1;
            ready_n    = 1'b0;
            busy_n     = 1'b1;
          end
        end
      end

      ST_SHIFT, ST_SWEEP_SHIFT: begin
        if (div_cnt_r == div_last_lp) begin
          div_cnt_n = '0;
          if (bit_cnt_r == last_bit_r) begin
            state_n   = (state_r == ST_SHIFT) ? ST_GAP : ST_SWEEP_GAP;
            gap_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt_r + 1'b1;
            frame_n   = frame_r >> 1;
            tag_n     = frame_r[1];
          end
        end else begin
          div_cnt_n = div_cnt_r + 1'b1;
          tag_n     = tag_data_o;
        end
      end

      ST_GAP, ST_SWEEP_GAP: begin
        if (gap_cnt_r == gap_last_lp) begin
          if (state_r == ST_GAP || node_r == node_last_lp) begin
            state_n = ST_IDLE;
            ready_n = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            // Next sweep packet starts immediately after this gap.
            state_n    = ST_SWEEP_SHIFT;
            node_n     = node_r + 1'b1;
            frame_n    = pack_frame(node_r + 1'b1, 1'b0, max_len_lp, '1);
            last_bit_n = sweep_last_lp;
            bit_cnt_n  = '0;
            div_cnt_n  = '0;
            tag_n      = 1'b1;
          end
        end else begin
          gap_cnt_n = gap_cnt_r + 1'b1;
        end
      end

      default: begin
        state_n = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r      <= ST_INIT;
      frame_r      <= '0;
      last_bit_r   <= '0;
      bit_cnt_r    <= '0;
      div_cnt_r    <= '0;
      gap_cnt_r    <= '0;
      node_r       <= '0;
      tag_data_o   <= 1'b0;
      ready_o      <= 1'b0;
      busy_o       <= 1'b0;
      sweep_done_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state_r      <= state_n;
      frame_r      <= frame_n;
      last_bit_r   <= last_bit_n;
      bit_cnt_r    <= bit_cnt_n;
      div_cnt_r    <= div_cnt_n;
      gap_cnt_r    <= gap_cnt_n;
      node_r       <= node_n;
      tag_data_o   <= tag_n;
      ready_o      <= ready_n;
      busy_o       <= busy_n;
      sweep_done_o <= done_n;
      err_o        <= err_n;
    end
  end

endmodule

// File: tb/tb_bsg_dmc_pearl_tag_sequencer.sv
// Bench for bsg_dmc_pearl_tag_sequencer: two instances (clk_div 1 and 3) against a queue-based
// per-cycle expected-waveform model, plus hand-derived frame vectors and corner sequences.
module tb_bsg_dmc_pearl_tag_sequencer;

  localparam int ELS = 32;
  localparam int W   = 16;
  localparam int GAP = 2;
  localparam int LGE = 5;
  localparam int LGW = 5;
  localparam int QN  = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, sweep_en, v, dnr;
  logic [4:0]  node, len;
  logic [15:0] payload;
  logic        ready0, tag0, busy0, done0, err0;
  logic        ready1, tag1, busy1, done1, err1;

  bsg_dmc_pearl_tag_sequencer #(.els_p(ELS), .max_payload_width_p(W), .clk_div_p(1), .gap_p(GAP)) dut0 (
    .clk_i(clk), .reset_n_i(reset_n), .sweep_en_i(sweep_en), .v_i(v), .node_id_i(node),
    .data_not_reset_i(dnr), .len_i(len), .payload_i(payload), .ready_o(ready0),
    .tag_data_o(tag0), .busy_o(busy0), .sweep_done_o(done0), .err_o(err0));

  bsg_dmc_pearl_tag_sequencer #(.els_p(ELS), .max_payload_width_p(W), .clk_div_p(3), .gap_p(GAP)) dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .sweep_en_i(sweep_en), .v_i(v), .node_id_i(node),
    .data_not_reset_i(dnr), .len_i(len), .payload_i(payload), .ready_o(ready1),
    .tag_data_o(tag1), .busy_o(busy1), .sweep_done_o(done1), .err_o(err1));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = -1000;

  // Reference model: the exact tag bit expected in each upcoming cycle, one stream per instance.
  int   div_of [2] = '{1, 3};
  logic mbuf  [2][QN];
  int   mhead [2];
  int   mtail [2];
  bit   mdone [2];
  bit   merr  [2];
  bit   mzero = 1'b1;

  logic cur_tag, cur_ready, cur_busy, cur_done, cur_err, cur_ready1;
  bit   hs0;

  typedef struct {
    logic [4:0]  node;
    logic        dnr;
    logic [4:0]  len;
    logic [15:0] pl;
    int          f;
    bit          err;
    logic [31:0] bits;
  } vec_t;
  vec_t tbl [6];

  function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, exp);
    end
  endfunction

  task automatic push_bit(input int i, input logic b);
    for (int r = 0; r < div_of[i]; r++) begin
      mbuf[i][mtail[i] % QN] = b;
      mtail[i]++;
    end
  endtask

  task automatic push_frame(input int i, input logic [4:0] nd, input logic d,
                            input logic [4:0] ln, input logic [15:0] pl);
    push_bit(i, 1'b1);
    for (int k = 0; k < LGE; k++) push_bit(i, nd[k]);
    push_bit(i, d);
    for (int k = 0; k < LGW; k++) push_bit(i, ln[k]);
    for (int k = 0; k < int'(ln); k++) push_bit(i, pl[k]);
    for (int k = 0; k < GAP; k++) push_bit(i, 1'b0);
  endtask

  // One clock cycle: check this cycle's outputs, then drive the inputs sampled at its end.
  task automatic tick(input logic tv, input logic [4:0] tn, input logic td, input logic [4:0] tl,
                      input logic [15:0] tp, input logic trst, input logic tsw);
    logic [4:0] got, exp;
    logic       rdy_e [2];
    bit         be;
    string      nm;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        got = {tag0, ready0, busy0, done0, err0};
        nm  = "model_div1";
      end else begin
        got = {tag1, ready1, busy1, done1, err1};
        nm  = "model_div3";
      end
      if (mzero) begin
        exp = '0;
      end else begin
        be = (mhead[i] != mtail[i]);
        if (!be) mdone[i] = 1'b1;
        exp = {be ? mbuf[i][mhead[i] % QN] : 1'b0, !be, be, mdone[i], merr[i]};
        if (be) mhead[i]++;
      end
      rdy_e[i] = exp[3];
      check(nm, 32'(got), 32'(exp));
    end
    cur_tag = tag0; cur_ready = ready0; cur_busy = busy0; cur_done = done0; cur_err = err0;
    cur_ready1 = ready1;
    hs0 = tv && ready0;
    reset_n = trst; sweep_en = tsw; v = tv; node = tn; dnr = td; len = tl; payload = tp;
    if (!trst) begin
      mzero = 1'b1;
      for (int i = 0; i < 2; i++) begin
        mhead[i] = 0; mtail[i] = 0; mdone[i] = 1'b0; merr[i] = 1'b0;
      end
    end else if (mzero) begin
      mzero = 1'b0;
      cyc   = 0;
      if (tsw)
        for (int i = 0; i < 2; i++)
          for (int n = 0; n < ELS; n++) push_frame(i, 5'(n), 1'b0, 5'(W), 16'hFFFF);
    end else begin
      for (int i = 0; i < 2; i++) begin
        merr[i] = 1'b0;
        if (tv && rdy_e[i]) begin
          if (int'(tn) >= ELS || int'(tl) > W) merr[i] = 1'b1;
          else push_frame(i, tn, td, tl, tp);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic run_vec(input vec_t e);
    int t;
    logic [31:0] got;
    logic [2:0]  rdy;
    t = 0; hs0 = 1'b0;
    while (!hs0 && t < 200) begin
      tick(1'b1, e.node, e.dnr, e.len, e.pl, 1'b1, 1'b0);
      t++;
    end
    check("vec_handshake", 32'(hs0), 32'd1);
    if (e.err) begin
      idle(1);
      check("vec_err_pulse", {28'd0, cur_err, cur_ready, cur_tag, cur_busy}, 32'hC);
    end else begin
      got = '0;
      for (int k = 0; k < e.f; k++) begin
        idle(1);
        got[k] = cur_tag;
      end
      check("vec_frame_bits", got, e.bits);
      for (int g = 0; g < GAP; g++) begin
        idle(1);
        rdy[2-g] = cur_ready | cur_tag;
      end
      idle(1);
      rdy[0] = cur_ready;
      check("vec_ready_return", 32'(rdy), 32'd1);
    end
  endtask

  initial begin
    int t, h1;
    logic [31:0] got;
    reset_n = 1'b0; sweep_en = 1'b0; v = 1'b0; node = '0; dnr = 1'b0; len = '0; payload = '0;
    for (int i = 0; i < 2; i++) begin
      mhead[i] = 0; mtail[i] = 0; mdone[i] = 1'b0; merr[i] = 1'b0;
    end

    tbl[0] = '{node: 5'd3,  dnr: 1'b1, len: 5'd4,  pl: 16'h000A, f: 16, err: 1'b0, bits: 32'h0000A247};
    tbl[1] = '{node: 5'd31, dnr: 1'b1, len: 5'd0,  pl: 16'h0000, f: 12, err: 1'b0, bits: 32'h0000007F};
    tbl[2] = '{node: 5'd5,  dnr: 1'b1, len: 5'd17, pl: 16'hFFFF, f: 0,  err: 1'b1, bits: 32'h0};
    tbl[3] = '{node: 5'd0,  dnr: 1'b0, len: 5'd16, pl: 16'hFFFF, f: 28, err: 1'b0, bits: 32'h0FFFF801};
    tbl[4] = '{node: 5'd21, dnr: 1'b0, len: 5'd3,  pl: 16'hFFF6, f: 15, err: 1'b0, bits: 32'h000061AB};
    tbl[5] = '{node: 5'd7,  dnr: 1'b1, len: 5'd31, pl: 16'h1234, f: 0,  err: 1'b1, bits: 32'h0};

    // Reset without sweep; first command lands at cycle 5.
    repeat (3) tick(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
    idle(4);
    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i]);
      if (i == 0) begin
        t = 0;
        while (!cur_ready1 && t < 200) begin
          idle(1);
          t++;
        end
        check("div3_ready_cycle", 32'(cyc), 32'd60);
      end
    end

    // Requester holding v_i across two commands: second accepted exactly after the gap.
    t = 0; hs0 = 1'b0;
    while (!hs0 && t < 200) begin tick(1'b1, 5'd31, 1'b1, 5'd0, 16'h0, 1'b1, 1'b0); t++; end
    check("b2b_hs1", 32'(hs0), 32'd1);
    h1 = cyc;
    t = 0; hs0 = 1'b0;
    while (!hs0 && t < 200) begin tick(1'b1, 5'd9, 1'b0, 5'd2, 16'h3, 1'b1, 1'b0); t++; end
    check("b2b_hs2", 32'(hs0), 32'd1);
    check("b2b_spacing", 32'(cyc - h1), 32'd15);

    // Reset while bit 7 of a frame is on the wire, then restart with a sweep.
    t = 0; hs0 = 1'b0;
    while (!hs0 && t < 200) begin tick(1'b1, 5'd3, 1'b1, 5'd4, 16'hA, 1'b1, 1'b0); t++; end
    check("abort_hs", 32'(hs0), 32'd1);
    idle(7);
    tick(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    check("abort_outputs_clear", {29'd0, cur_tag, cur_busy, cur_ready}, 32'd0);
    tick(1'b1, 5'd4, 1'b1, 5'd1, 16'h1, 1'b1, 1'b1);
    got = '0;
    for (int k = 0; k < 28; k++) begin
      tick(1'b1, 5'd4, 1'b1, 5'd1, 16'h1, 1'b1, 1'b0);
      got[k] = cur_tag;
    end
    check("sweep_node0_frame", got, 32'h0FFFF801);
    t = 0; hs0 = 1'b0;
    while (!hs0 && t < 2000) begin tick(1'b1, 5'd4, 1'b1, 5'd1, 16'h1, 1'b1, 1'b0); t++; end
    check("sweep_ready_cycle", 32'(cyc), 32'd961);
    check("sweep_done_flag", 32'(cur_done), 32'd1);

    // Random traffic; fields wander while v_i is held, illegal lengths included.
    for (int k = 0; k < 3000; k++)
      tick(1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom), 5'($urandom_range(0, 20)),
           16'($urandom), 1'b1, 1'b0);
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
